sigmaw_argmin: RTL and testbench

SIGMAW_ARGMIN -- requirements
Module: sigmaw_argmin

---
 rtl/otsu_pkg.sv | 14 +
 rtl/sigmaw_argmin.sv | 101 ++++++++++
 tb/tb_sigmaw_argmin.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/otsu_pkg.sv
// Shared definitions for the Otsu threshold datapath: FSM encoding and default widths.
package otsu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int OTSU_IW    = 33;
    localparam int OTSU_TW    = 8;
    localparam int OTSU_NBINS = 256;

endpackage

// File: rtl/sigmaw_argmin.sv
// Finds the threshold index with the smallest within-class variance over one sweep.
// Optional min_sigmaW output is enabled by defining SIGMAW_ARGMIN_MINVAL_OUT_EN.
module sigmaw_argmin
    import otsu_pkg::*;
#(
    parameter int IW    = OTSU_IW,
    parameter int TW    = OTSU_TW,
    parameter int NBINS = OTSU_NBINS
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [IW-1:0] sigmaW_sq,
    input  logic          in_skip,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [TW-1:0] thresh,
    output logic          out_none,
`ifdef SIGMAW_ARGMIN_MINVAL_OUT_EN
    output logic [IW-1:0] min_sigmaW,
`endif
    output state_t        dbg_state
);

    // Handshakes: a sample transfers on a rising edge where in_valid && in_ready;
    // the result transfers on a rising edge where out_valid && out_ready. Neither
    // ready depends combinationally on the matching valid.

    state_t        state;
    state_t        state_nxt;
    logic [TW-1:0] t_q;
    logic          min_valid;
    logic [IW-1:0] min_val;
    logic [TW-1:0] min_t;

    logic accept;
    logic last;
    logic take;
    logic clear;

    assign in_ready = (state == SCAN);
    // A sample arriving together with start belongs to the aborted sweep.
    assign accept   = in_valid && in_ready && !start;
    assign last     = (t_q == TW'(NBINS - 1));
    assign take     = accept && !in_skip && (!min_valid || (sigmaW_sq < min_val));
    assign clear    = start && ((state != DONE) || out_ready);

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) state_nxt = SCAN;
            end
            SCAN: begin
                if (start)             state_nxt = SCAN;
                else if (accept && last) state_nxt = DONE;
            end
            DONE: begin
                if (out_ready) state_nxt = start ? SCAN : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            t_q       <= '0;
            min_valid <= 1'b0;
            min_val   <= '0;
            min_t     <= '0;
        end else if (clear) begin
            t_q       <= '0;
            min_valid <= 1'b0;
        end else if (accept) begin
            // Counter parks on the last index rather than wrapping.
            if (!last) t_q <= t_q + 1'b1;
            if (take) begin
                min_val   <= sigmaW_sq;
                min_t     <= t_q;
                min_valid <= 1'b1;
            end
        end
    end

    assign out_valid = (state == DONE);
    assign out_none  = (state == DONE) && !min_valid;
    assign thresh    = ((state == DONE) && min_valid) ? min_t : '0;
    assign dbg_state = state;

`ifdef SIGMAW_ARGMIN_MINVAL_OUT_EN
    assign min_sigmaW = (state == DONE) ? min_val : '0;
`endif

endmodule

// File: tb/tb_sigmaw_argmin.sv
// Directed and randomized bench for sigmaw_argmin with NBINS=4.
module tb_sigmaw_argmin;
    import otsu_pkg::*;

    localparam int IW    = 33;
    localparam int TW    = 8;
    localparam int NBINS = 4;
    localparam int EW    = 1 + TW + IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] sigmaW_sq = '0;
    logic          in_skip = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [TW-1:0] thresh;
    logic          out_none;
    state_t        dbg_state;
`ifdef SIGMAW_ARGMIN_MINVAL_OUT_EN
    logic [IW-1:0] min_sigmaW;
`endif

    int checks = 0;
    int failures = 0;
    logic [EW-1:0] exp_q[$];
    logic [IW-1:0] sv [NBINS];
    logic          sk [NBINS];
    logic [IW-1:0] all_ones;

    sigmaw_argmin #(.IW(IW), .TW(TW), .NBINS(NBINS)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sigmaW_sq (sigmaW_sq),
        .in_skip   (in_skip),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .thresh    (thresh),
        .out_none  (out_none),
`ifdef SIGMAW_ARGMIN_MINVAL_OUT_EN
        .min_sigmaW(min_sigmaW),
`endif
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    function automatic logic [EW-1:0] pk(input logic none, input logic [TW-1:0] thr,
                                         input logic [IW-1:0] mv);
        return {none, thr, mv};
    endfunction

    // Reference argmin over the loaded sweep: strict less-than keeps the earliest index.
    function automatic logic [EW-1:0] model();
        logic          none = 1'b1;
        logic [TW-1:0] best_t = '0;
        logic [IW-1:0] best_v = '0;
        for (int i = 0; i < NBINS; i++) begin
            if (!sk[i] && (none || sv[i] < best_v)) begin
                none = 1'b0;
                best_v = sv[i];
                best_t = TW'(i);
            end
        end
        return pk(none, best_t, best_v);
    endfunction

    task automatic load(input logic [IW-1:0] a, b, c, d, input logic [3:0] skm);
        sv[0] = a; sv[1] = b; sv[2] = c; sv[3] = d;
        for (int i = 0; i < NBINS; i++) sk[i] = skm[i];
    endtask

    task automatic send(input logic [IW-1:0] v, input logic s);
        int   n;
        logic acc;
        repeat ($urandom_range(0, 1)) tick();
        in_valid = 1'b1;
        sigmaW_sq = v;
        in_skip = s;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 20) begin
            acc = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        in_skip = 1'b0;
        check("send_accept", {63'd0, acc}, 64'd1);
    endtask

    // Drives the loaded sweep and expects out_valid on the cycle after the last sample.
    task automatic run_sweep(input string tag, input logic [EW-1:0] expv);
        exp_q.push_back(expv);
        for (int i = 0; i < NBINS; i++) send(sv[i], sk[i]);
        check({tag, "_latency"}, {63'd0, out_valid}, 64'd1);
    endtask

    task automatic collect(input string tag, input logic restart);
        int n;
        logic [EW-1:0] e;
        n = 0;
        while (!out_valid && n < 20) begin
            tick();
            n++;
        end
        check({tag, "_out_valid"}, {63'd0, out_valid}, 64'd1);
        check({tag, "_queue"}, {63'd0, exp_q.size() > 0}, 64'd1);
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
        check({tag, "_thresh"}, {56'd0, thresh}, {56'd0, e[IW +: TW]});
        check({tag, "_none"}, {63'd0, out_none}, {63'd0, e[EW-1]});
`ifdef SIGMAW_ARGMIN_MINVAL_OUT_EN
        if (!e[EW-1]) check({tag, "_min"}, {31'd0, min_sigmaW}, {31'd0, e[IW-1:0]});
`endif
        out_ready = 1'b1;
        start = restart;
        tick();
        out_ready = 1'b0;
        start = 1'b0;
        check({tag, "_released"}, {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        all_ones = '1;

        // Reset state
        #2;
        check("rst_in_ready", {63'd0, in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_thresh", {56'd0, thresh}, 64'd0);
        check("rst_none", {63'd0, out_none}, 64'd0);
        check("rst_state", {62'd0, dbg_state}, {62'd0, IDLE});
        tick();
        rst_n = 1'b1;
        tick();
        check("idle_in_ready", {63'd0, in_ready}, 64'd0);

        // Basic sweep
        pulse_start();
        check("scan_in_ready", {63'd0, in_ready}, 64'd1);
        load(50, 20, 30, 40, 4'b0000);
        run_sweep("basic", pk(1'b0, 8'd1, 33'd20));
        collect("basic", 1'b0);

        // Tie keeps lowest index
        pulse_start();
        load(9, 5, 5, 7, 4'b0000);
        run_sweep("tie", pk(1'b0, 8'd1, 33'd5));
        collect("tie", 1'b0);

        // Skipped candidates never win
        pulse_start();
        load(3, 8, 6, 7, 4'b0101);
        run_sweep("skip", pk(1'b0, 8'd3, 33'd7));
        collect("skip", 1'b0);

        pulse_start();
        load(1, 2, 3, 4, 4'b1111);
        run_sweep("allskip", pk(1'b1, 8'd0, 33'd0));
        collect("allskip", 1'b0);

        // Result held while consumer stalls; start in DONE ignored
        pulse_start();
        load(4, 3, 2, 1, 4'b0000);
        run_sweep("hold", pk(1'b0, 8'd3, 33'd1));
        for (int i = 0; i < 5; i++) begin
            check("hold_valid", {63'd0, out_valid}, 64'd1);
            check("hold_thresh", {56'd0, thresh}, 64'd3);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            start = (i == 2);
            tick();
        end
        start = 1'b0;
        collect("hold", 1'b0);
        check("hold_back_idle", {63'd0, in_ready}, 64'd0);

        // Restart mid-sweep
        pulse_start();
        send(10, 1'b0);
        send(11, 1'b0);
        pulse_start();
        load(1, 2, 3, 0, 4'b0000);
        run_sweep("abort", pk(1'b0, 8'd3, 33'd0));
        collect("abort", 1'b0);

        // Sample presented with start is discarded
        pulse_start();
        send(10, 1'b0);
        start = 1'b1;
        in_valid = 1'b1;
        sigmaW_sq = 0;
        tick();
        start = 1'b0;
        in_valid = 1'b0;
        load(5, 6, 7, 1, 4'b0000);
        exp_q.push_back(pk(1'b0, 8'd3, 33'd1));
        for (int i = 0; i < 3; i++) send(sv[i], sk[i]);
        check("discard_not_done", {63'd0, out_valid}, 64'd0);
        send(sv[3], sk[3]);
        check("discard_latency", {63'd0, out_valid}, 64'd1);
        collect("discard", 1'b1);
        check("restart_in_ready", {63'd0, in_ready}, 64'd1);

        // Full-width compare (sweep already started by the DONE+start handoff)
        load(all_ones, all_ones, all_ones - 1, all_ones, 4'b0000);
        run_sweep("wide", pk(1'b0, 8'd2, all_ones - 1));
        collect("wide", 1'b0);

        // Reset during SCAN
        pulse_start();
        send(1, 1'b0);
        send(2, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        check("mrst_in_ready", {63'd0, in_ready}, 64'd0);
        check("mrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("mrst_thresh", {56'd0, thresh}, 64'd0);
        check("mrst_none", {63'd0, out_none}, 64'd0);
        check("mrst_state", {62'd0, dbg_state}, {62'd0, IDLE});
        #3 rst_n = 1'b1;
        tick();
        for (int i = 0; i < 6; i++) begin
            in_valid = 1'b1;
            sigmaW_sq = 9;
            tick();
            check("mrst_no_result", {63'd0, out_valid}, 64'd0);
        end
        in_valid = 1'b0;

        // Randomized sweeps against the reference argmin
        for (int r = 0; r < 4; r++) begin
            pulse_start();
            for (int i = 0; i < NBINS; i++) begin
                sv[i] = IW'($urandom_range(0, 7));
                sk[i] = ($urandom_range(0, 3) == 0);
            end
            run_sweep("rand", model());
            collect("rand", 1'b0);
        end

        check("queue_empty", {32'd0, exp_q.size()}, 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
